// File: rtl/rvb_bfxp_pipe.sv
// Elastic-pipelined bit-field extract-and-place unit.
// Slot 0 holds the extracted field; later slots hold the placed result.
module rvb_bfxp_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     din_valid,
  output logic                     din_ready,
  input  logic [XLEN-1:0]          din_rs1,
  input  logic [XLEN-1:0]          din_rs2,
  input  logic [$clog2(XLEN)-1:0]  din_start,
  input  logic [$clog2(XLEN):0]    din_len,
  input  logic [$clog2(XLEN)-1:0]  din_dest,
  input  logic                     din_sext,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic [XLEN-1:0]          dout_rd
);

  localparam int SW = $clog2(XLEN);
  localparam int LW = SW + 1;
  localparam logic [XLEN-1:0] ONE      = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [LW-1:0]   LEN_MAX  = LW'(XLEN);

  function automatic logic [XLEN-1:0] len_mask(input logic [LW-1:0] len);
    if (len >= LEN_MAX) begin
      return ALL_ONES;
    end else begin
      return (ONE << len) - ONE;
    end
  endfunction

  function automatic logic [XLEN-1:0] place(
    input logic [XLEN-1:0] rs1,
    input logic [XLEN-1:0] f,
    input logic [LW-1:0]   len,
    input logic [SW-1:0]   dest,
    input logic            sext
  );
    logic [XLEN-1:0] m;
    logic [XLEN-1:0] s;
    logic [LW-1:0]   lm1;
    logic            sign;
    m   = len_mask(len);
    lm1 = len - {{(LW-1){1'b0}}, 1'b1};
    if (len == {LW{1'b0}}) begin
      sign = 1'b0;
    end else begin
      sign = f[lm1[SW-1:0]];
    end
    s = sign ? (f | ~m) : f;
    if (sext) begin
      return (rs1 & ~(ALL_ONES << dest)) | (s << dest);
    end else begin
      return (rs1 & ~(m << dest)) | (f << dest);
    end
  endfunction

  logic [STAGES-1:0] valid;
  logic [STAGES-1:0] take;
  logic [LW-1:0]     len_c;
  logic [XLEN-1:0]   field;

  logic [XLEN-1:0]   s0_rs1;
  logic [XLEN-1:0]   s0_field;
  logic [LW-1:0]     s0_len;
  logic [SW-1:0]     s0_dest;
  logic              s0_sext;
  logic [XLEN-1:0]   placed;

  // A slot can take new contents when it is empty or its occupant moves on.
  always_comb begin
    logic chain;
    take  = '0;
    chain = dout_ready;
    for (int k = STAGES-1; k >= 0; k--) begin
      take[k] = chain | ~valid[k];
      chain   = take[k];
    end
  end

  assign din_ready  = ~reset & take[0];
  assign dout_valid = valid[STAGES-1];

  assign len_c  = (din_len > LEN_MAX) ? LEN_MAX : din_len;
  assign field  = (din_rs2 >> din_start) & len_mask(len_c);
  assign placed = place(s0_rs1, s0_field, s0_len, s0_dest, s0_sext);

  // Valid bits for every slot.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid <= '0;
    end else begin
      if (take[0]) valid[0] <= din_valid;
      for (int k = 1; k < STAGES; k++) begin
        if (take[k]) valid[k] <= valid[k-1];
      end
    end
  end

  // Slot 0 payload, loaded only on an input transfer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s0_rs1   <= '0;
      s0_field <= '0;
      s0_len   <= '0;
      s0_dest  <= '0;
      s0_sext  <= 1'b0;
    end else if (take[0] && din_valid) begin
      s0_rs1   <= din_rs1;
      s0_field <= field;
      s0_len   <= len_c;
      s0_dest  <= din_dest;
      s0_sext  <= din_sext;
    end
  end

  generate
    if (STAGES == 1) begin : g_one
      assign dout_rd = placed;
    end else begin : g_multi
      logic [XLEN-1:0] rd_q [1:STAGES-1];

      // Result slots; data moves only with a valid occupant so it holds when empty.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          for (int k = 1; k < STAGES; k++) rd_q[k] <= '0;
        end else begin
          if (take[1] && valid[0]) rd_q[1] <= placed;
          for (int k = 2; k < STAGES; k++) begin
            if (take[k] && valid[k-1]) rd_q[k] <= rd_q[k-1];
          end
        end
      end

      assign dout_rd = rd_q[STAGES-1];
    end
  endgenerate

endmodule

// File: tb/tb_rvb_bfxp_pipe.sv
// Self-checking bench: one 32-bit/2-stage unit and 64-bit units with 1, 2 and 3 stages,
// compared against a bit-by-bit reference model.
module tb_rvb_bfxp_pipe;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        vld  [4];
  logic        drdy [4];
  logic        ov   [4];
  logic        ordy [4];
  logic        sx   [4];
  logic [63:0] rs1  [4];
  logic [63:0] rs2  [4];
  logic [63:0] rd   [4];
  logic [5:0]  st   [4];
  logic [5:0]  ds   [4];
  logic [6:0]  ln   [4];
  logic [31:0] rd32;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [63:0] val;
    int          acc;
  } exp_t;
  exp_t q[$];

  always @(posedge clock) cyc <= cyc + 1;

  rvb_bfxp_pipe #(.XLEN(32), .STAGES(2)) u32 (
    .clock(clock), .reset(reset),
    .din_valid(vld[0]), .din_ready(drdy[0]),
    .din_rs1(rs1[0][31:0]), .din_rs2(rs2[0][31:0]),
    .din_start(st[0][4:0]), .din_len(ln[0][5:0]), .din_dest(ds[0][4:0]),
    .din_sext(sx[0]),
    .dout_valid(ov[0]), .dout_ready(ordy[0]), .dout_rd(rd32)
  );
  assign rd[0] = {32'd0, rd32};

  for (genvar g = 1; g < 4; g++) begin : g_dut64
    rvb_bfxp_pipe #(.XLEN(64), .STAGES(g)) u64 (
      .clock(clock), .reset(reset),
      .din_valid(vld[g]), .din_ready(drdy[g]),
      .din_rs1(rs1[g]), .din_rs2(rs2[g]),
      .din_start(st[g]), .din_len(ln[g]), .din_dest(ds[g]),
      .din_sext(sx[g]),
      .dout_valid(ov[g]), .dout_ready(ordy[g]), .dout_rd(rd[g])
    );
  end

  function automatic int xl(input int d);
    return (d == 0) ? 32 : 64;
  endfunction

  function automatic int stg(input int d);
    return (d == 0) ? 2 : d;
  endfunction

  // Each result bit: below dest keeps rs1; then the field bits; above the field either
  // the field's top bit (sext) or rs1.
  function automatic logic [63:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                        input int start, input int len, input int dest, input bit sext);
    logic [63:0] r;
    int j;
    r = 64'd0;
    if (len > w) len = w;
    for (int i = 0; i < w; i++) begin
      j = i - dest;
      if (i < dest)        r[i] = a[i];
      else if (j < len)    r[i] = (start + j < w) ? b[start + j] : 1'b0;
      else if (sext)       r[i] = (len == 0) ? 1'b0 : ((start + len - 1 < w) ? b[start + len - 1] : 1'b0);
      else                 r[i] = a[i];
    end
    return r;
  endfunction

  task automatic idle_all();
    for (int i = 0; i < 4; i++) begin
      vld[i] = 1'b0; ordy[i] = 1'b1; sx[i] = 1'b0;
      rs1[i] = 64'd0; rs2[i] = 64'd0; st[i] = 6'd0; ds[i] = 6'd0; ln[i] = 7'd0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_all();
    repeat (2) @(posedge clock);
    @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (drdy[i] !== 1'b0 || ov[i] !== 1'b0 || rd[i] !== 64'd0) begin
        errors++;
        $display("FAIL reset_state[%0d]: got ready=%b valid=%b rd=%h want 0 0 0", i, drdy[i], ov[i], rd[i]);
      end
    end
    reset = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (drdy[i] !== 1'b1) begin
        errors++;
        $display("FAIL ready_after_reset[%0d]: got %b want 1", i, drdy[i]);
      end
    end
  endtask

  task automatic send_one(input int d, input logic [63:0] a, input logic [63:0] b, input int s,
                          input int l, input int t, input bit x, input logic [63:0] exp, input string nm);
    bit got;
    int lat;
    got = 1'b0;
    lat = -1;
    @(posedge clock); #1;
    rs1[d] = a; rs2[d] = b; st[d] = 6'(s); ln[d] = 7'(l); ds[d] = 6'(t); sx[d] = x;
    vld[d] = 1'b1; ordy[d] = 1'b1;
    @(negedge clock);
    checks++;
    if (drdy[d] !== 1'b1) begin
      errors++;
      $display("FAIL %s_accept: got ready=%b want 1", nm, drdy[d]);
    end
    @(posedge clock); #1;
    vld[d] = 1'b0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clock);
      if (!got && ov[d] === 1'b1) begin
        got = 1'b1;
        lat = j;
        checks++;
        if (rd[d] !== exp) begin
          errors++;
          $display("FAIL %s_value: got %h want %h", nm, rd[d], exp);
        end
      end
      if (got) break;
    end
    checks++;
    if (lat != stg(d) - 1) begin
      errors++;
      $display("FAIL %s_latency: got %0d want %0d (edges after accept edge)", nm, lat, stg(d) - 1);
    end
  endtask

  task automatic test_directed();
    send_one(0, 64'hFFFFFFFF, 64'h12345678, 8, 8, 4, 1'b0, 64'hFFFFF56F, "extract");
    send_one(0, 64'h0, 64'h000000F0, 4, 4, 8, 1'b1, 64'hFFFFFF00, "sext_neg");
    send_one(0, 64'h0, 64'h00000070, 4, 4, 8, 1'b1, 64'h00000700, "sext_pos");
    send_one(0, 64'hAAAAAAAA, 64'h12345678, 0, 32, 16, 1'b0, 64'h5678AAAA, "len_full");
    send_one(0, 64'h9ABCDEF0, 64'h12345678, 3, 0, 7, 1'b0, 64'h9ABCDEF0, "len_zero");
    send_one(0, 64'h9ABCDEF0, 64'h12345678, 3, 0, 7, 1'b1, 64'h00000070, "len_zero_sext");
    send_one(0, 64'h9ABCDEF0, 64'h12345678, 0, 32, 0, 1'b0, 64'h12345678, "copy");
    send_one(0, 64'h9ABCDEF0, 64'h12345678, 0, 45, 0, 1'b0, 64'h12345678, "len_clamp");
    send_one(1, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 0, 64, 0, 1'b0, 64'hFEDCBA9876543210, "copy64");
    send_one(3, 64'h0123456789ABCDEF, 64'h0000000000000001, 0, 64, 63, 1'b1, 64'h8123456789ABCDEF, "sext64_top");
    send_one(2, 64'h0123456789ABCDEF, 64'h0000000000000002, 0, 64, 63, 1'b1, 64'h0123456789ABCDEF, "sext64_top0");
  endtask

  task automatic test_stream(input int d, input int n);
    int acc_n, out_n, w;
    bit stall_prev, exp_rdy, exp_v;
    logic [63:0] held;
    exp_t e;
    acc_n = 0; out_n = 0; stall_prev = 1'b0; held = 64'd0; w = xl(d);
    q.delete();
    for (int c = 0; c < n * 4 + 200 && out_n < n; c++) begin
      @(posedge clock); #1;
      vld[d] = (acc_n < n);
      rs1[d] = {$urandom, $urandom};
      rs2[d] = {$urandom, $urandom};
      st[d]  = 6'($urandom_range(0, w - 1));
      ds[d]  = 6'($urandom_range(0, w - 1));
      ln[d]  = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(w, 2 * w - 1)) : 7'($urandom_range(0, w));
      sx[d]  = 1'($urandom_range(0, 1));
      ordy[d] = (c >= 50 && c < 55) ? 1'b0 : ($urandom_range(0, 3) != 0);
      @(negedge clock);
      exp_rdy = (q.size() < stg(d)) || ordy[d];
      checks++;
      if (drdy[d] !== exp_rdy) begin
        errors++;
        $display("FAIL stream%0d_din_ready: got %b want %b at cycle %0d", d, drdy[d], exp_rdy, c);
      end
      exp_v = (q.size() > 0) && (cyc >= q[0].acc + stg(d) - 1);
      checks++;
      if (ov[d] !== exp_v) begin
        errors++;
        $display("FAIL stream%0d_dout_valid: got %b want %b at cycle %0d", d, ov[d], exp_v, c);
      end
      if (stall_prev) begin
        checks++;
        if (rd[d] !== held) begin
          errors++;
          $display("FAIL stream%0d_stall_hold: got %h want %h", d, rd[d], held);
        end
      end
      if (ov[d] === 1'b1 && ordy[d] && q.size() > 0) begin
        checks++;
        if (rd[d] !== q[0].val) begin
          errors++;
          $display("FAIL stream%0d_result[%0d]: got %h want %h", d, out_n, rd[d], q[0].val);
        end
        void'(q.pop_front());
        out_n++;
      end
      stall_prev = (ov[d] === 1'b1) && !ordy[d];
      held = rd[d];
      if (vld[d] && drdy[d] === 1'b1) begin
        e.val = model(w, rs1[d], rs2[d], int'(st[d]), int'(ln[d]), int'(ds[d]), sx[d]);
        e.acc = cyc + 1;
        q.push_back(e);
        acc_n++;
      end
    end
    vld[d] = 1'b0;
    ordy[d] = 1'b1;
    checks++;
    if (out_n != n || q.size() != 0) begin
      errors++;
      $display("FAIL stream%0d_complete: got %0d results (%0d pending) want %0d", d, out_n, q.size(), n);
    end
  endtask

  task automatic test_reset_midflight(input int d);
    logic [63:0] exp;
    @(posedge clock); #1;
    ordy[d] = 1'b0;
    vld[d]  = 1'b1;
    for (int k = 0; k < stg(d); k++) begin
      rs1[d] = {$urandom, $urandom}; rs2[d] = {$urandom, $urandom};
      st[d] = 6'd1; ln[d] = 7'd5; ds[d] = 6'd2; sx[d] = 1'b1;
      @(posedge clock); #1;
    end
    vld[d] = 1'b1;
    @(negedge clock);
    checks++;
    if (drdy[d] !== 1'b0 || ov[d] !== 1'b1) begin
      errors++;
      $display("FAIL full_%0d: got ready=%b valid=%b want 0 1", d, drdy[d], ov[d]);
    end
    @(posedge clock); #3;
    vld[d] = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (ov[d] !== 1'b0 || rd[d] !== 64'd0 || drdy[d] !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_%0d: got valid=%b rd=%h ready=%b want 0 0 0", d, ov[d], rd[d], drdy[d]);
    end
    @(negedge clock);
    reset = 1'b0;
    ordy[d] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      checks++;
      if (ov[d] !== 1'b0) begin
        errors++;
        $display("FAIL stale_after_reset_%0d: got valid=%b want 0", d, ov[d]);
      end
    end
    exp = model(xl(d), 64'hFFFFFFFF, 64'h12345678, 8, 8, 4, 1'b0);
    send_one(d, 64'hFFFFFFFF, 64'h12345678, 8, 8, 4, 1'b0, exp, "post_reset");
  endtask

  initial begin
    reset = 1'b1;
    idle_all();
    test_reset();
    test_directed();
    for (int d = 0; d < 4; d++) test_stream(d, 1000);
    test_reset_midflight(0);
    test_reset_midflight(1);
    test_reset_midflight(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
